// File: rtl/alu_arb_pkg.sv
// Shared constants for the ALU share arbiter: widths, flag bit
// positions and the func3/func7 encodings used by the shared ALU.
package alu_arb_pkg;

    localparam int XLEN  = 64;
    localparam int NFLAG = 4;

    // Flag vector layout is {overflow, eq, lt, gt}
    localparam int FLAG_GT  = 0;
    localparam int FLAG_LT  = 1;
    localparam int FLAG_EQ  = 2;
    localparam int FLAG_OVF = 3;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_SLL    = 3'b001;
    localparam logic [2:0] F3_AND    = 3'b111;
    localparam logic [6:0] F7_SUB    = 7'b0100000;

    function automatic logic [NFLAG-1:0] pack_flags(
        input logic ovf,
        input logic eq,
        input logic lt,
        input logic gt
    );
        logic [NFLAG-1:0] f;
        f           = '0;
        f[FLAG_OVF] = ovf;
        f[FLAG_EQ]  = eq;
        f[FLAG_LT]  = lt;
        f[FLAG_GT]  = gt;
        return f;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or above ptr,
// wrapping. Ports: elig/ptr in; one-hot grant, binary idx, any out.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] elig,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any && elig[(int'(ptr) + k) % NREQ]) begin
                grant[(int'(ptr) + k) % NREQ] = 1'b1;
                idx = IDW'((int'(ptr) + k) % NREQ);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external ALU between NREQ requesters with round-robin issue
// and a registered 1-deep response slot per requester.
// Ports: req_* issue handshake, rsp_* response handshake, alu_* to/from
// the shared ALU, busy when any slot is full or an op issues.
module alu_share_arbiter #(
    parameter int NREQ = 2,
    parameter int XLEN = alu_arb_pkg::XLEN,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*XLEN-1:0] req_op0,
    input  logic [NREQ*XLEN-1:0] req_op1,
    input  logic [NREQ*3-1:0]    req_func3,
    input  logic [NREQ*7-1:0]    req_func7,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [NREQ*XLEN-1:0] rsp_result,
    output logic [NREQ*4-1:0]    rsp_flags,
    output logic [XLEN-1:0]      alu_op0,
    output logic [XLEN-1:0]      alu_op1,
    output logic [2:0]           alu_func3,
    output logic [6:0]           alu_func7,
    input  logic [XLEN-1:0]      alu_result,
    input  logic                 alu_overflow,
    input  logic                 alu_eq,
    input  logic                 alu_lt,
    input  logic                 alu_gt,
    output logic                 busy
);

    import alu_arb_pkg::*;

    logic [NREQ-1:0]  elig;
    logic [NREQ-1:0]  gnt_raw;
    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gidx;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   ptr_nxt;
    logic             any_raw;
    logic [NFLAG-1:0] alu_flags;

    // A full slot can take a new op only if it is drained this cycle
    assign elig = req_valid & (~rsp_valid | rsp_ready);

    rr_arbiter #(
        .NREQ(NREQ),
        .IDW (IDW)
    ) u_rr (
        .elig (elig),
        .ptr  (rr_ptr),
        .grant(gnt_raw),
        .idx  (gidx),
        .any  (any_raw)
    );

    // Nothing is accepted while reset is asserted
    assign gnt       = rst_n ? gnt_raw : '0;
    assign req_ready = gnt;
    assign busy      = (|rsp_valid) || (|gnt);

    // idx is 0 when nothing is eligible, so the ALU sees requester 0
    assign alu_op0   = req_op0[gidx*XLEN +: XLEN];
    assign alu_op1   = req_op1[gidx*XLEN +: XLEN];
    assign alu_func3 = req_func3[gidx*3 +: 3];
    assign alu_func7 = req_func7[gidx*7 +: 7];
    assign alu_flags = pack_flags(alu_overflow, alu_eq, alu_lt, alu_gt);

    assign ptr_nxt = (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else begin
            if (any_raw) begin
                rr_ptr <= ptr_nxt;
            end
            for (int i = 0; i < NREQ; i++) begin
                // A new grant outranks a same-cycle consume
                if (gnt[i]) begin
                    rsp_valid[i]                <= 1'b1;
                    rsp_result[i*XLEN +: XLEN]  <= alu_result;
                    rsp_flags[i*NFLAG +: NFLAG] <= alu_flags;
                end else if (rsp_ready[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter with a behavioural ALU and a
// transaction-level model of grants and response slots.
module tb_alu_share_arbiter;

    import alu_arb_pkg::*;

    localparam int N = 2;
    localparam int W = 64;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*W-1:0] req_op0, req_op1, rsp_result;
    logic [N*3-1:0] req_func3;
    logic [N*7-1:0] req_func7;
    logic [N*4-1:0] rsp_flags;
    logic [W-1:0]   alu_op0, alu_op1, alu_result;
    logic [2:0]     alu_func3;
    logic [6:0]     alu_func7;
    logic           alu_overflow, alu_eq, alu_lt, alu_gt, busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.NREQ(N), .XLEN(W), .IDW(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_func3(req_func3), .req_func7(req_func7),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .alu_op0(alu_op0), .alu_op1(alu_op1),
        .alu_func3(alu_func3), .alu_func7(alu_func7),
        .alu_result(alu_result), .alu_overflow(alu_overflow),
        .alu_eq(alu_eq), .alu_lt(alu_lt), .alu_gt(alu_gt),
        .busy(busy)
    );

    // Shared ALU: returns {ovf, eq, lt, gt, result}; ovf is carry/borrow out
    function automatic logic [67:0] alu_fn(input logic [63:0] a, input logic [63:0] b,
                                           input logic [2:0] f3, input logic [6:0] f7);
        logic [64:0] s;
        logic [63:0] r;
        logic        ov;
        ov = 1'b0;
        r  = '0;
        s  = '0;
        case (f3)
            F3_ADDSUB: begin
                if (f7 == F7_SUB) s = {1'b0, a} - {1'b0, b};
                else              s = {1'b0, a} + {1'b0, b};
                r  = s[63:0];
                ov = s[64];
            end
            F3_SLL:  r = a << b[5:0];
            F3_AND:  r = a & b;
            default: r = '0;
        endcase
        return {ov, a == b, a < b, a > b, r};
    endfunction

    always_comb begin
        {alu_overflow, alu_eq, alu_lt, alu_gt, alu_result} =
            alu_fn(alu_op0, alu_op1, alu_func3, alu_func7);
    end

    // Reference model state
    int           m_ptr;
    logic [N-1:0] m_v;
    logic [W-1:0] m_res [N];
    logic [3:0]   m_fl  [N];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b,
                           input logic [2:0] f3, input logic [6:0] f7);
        req_op0[i*W +: W] = a;
        req_op1[i*W +: W] = b;
        req_func3[i*3 +: 3] = f3;
        req_func7[i*7 +: 7] = f7;
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_v   = '0;
        for (int i = 0; i < N; i++) begin
            m_res[i] = '0;
            m_fl[i]  = '0;
        end
    endtask

    // Called at the falling edge with inputs already applied; checks the
    // cycle against the model, then advances through one rising edge.
    task automatic tick(output int g);
        logic [N-1:0] exp_rdy;
        logic [67:0]  r;
        int           gi;
        int           j;
        #1;
        gi = -1;
        if (rst_n) begin
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (gi < 0 && req_valid[j] && (!m_v[j] || rsp_ready[j])) gi = j;
            end
        end
        exp_rdy = (gi >= 0) ? N'(1) << gi : '0;
        check("req_ready", req_ready, exp_rdy);
        check("rsp_valid", rsp_valid, m_v);
        check("busy", busy, (|m_v) || (gi >= 0));
        j = (gi >= 0) ? gi : 0;
        check("alu_op0", alu_op0, req_op0[j*W +: W]);
        check("alu_fn", {alu_func7, alu_func3}, {req_func7[j*7 +: 7], req_func3[j*3 +: 3]});
        for (int i = 0; i < N; i++) begin
            if (m_v[i]) begin
                check("rsp_result", rsp_result[i*W +: W], m_res[i]);
                check("rsp_flags", rsp_flags[i*4 +: 4], m_fl[i]);
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (i == gi) begin
                    m_v[i] = 1'b1;
                    r = alu_fn(req_op0[i*W +: W], req_op1[i*W +: W],
                               req_func3[i*3 +: 3], req_func7[i*7 +: 7]);
                    m_fl[i]  = r[67:64];
                    m_res[i] = r[63:0];
                end else if (rsp_ready[i]) begin
                    m_v[i] = 1'b0;
                end
            end
            if (gi >= 0) m_ptr = (gi + 1) % N;
        end
        g = gi;
        @(negedge clk);
    endtask

    typedef struct {
        int          rq;
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] res;
        logic [3:0]  fl;
    } vec_t;

    vec_t vecs [7];
    int   g;
    int   seq [6];
    logic [N-1:0] hold;

    initial begin
        vecs[0] = '{0, 64'd5,    64'd3,    F3_ADDSUB, 7'd0,   64'd8,    4'b0001};
        vecs[1] = '{1, 64'd10,   64'd4,    F3_ADDSUB, F7_SUB, 64'd6,    4'b0001};
        vecs[2] = '{0, 64'd1,    64'd4,    F3_SLL,    7'd0,   64'd16,   4'b0010};
        vecs[3] = '{1, '1,       '1,       F3_ADDSUB, 7'd0,   64'hFFFF_FFFF_FFFF_FFFE, 4'b1100};
        vecs[4] = '{0, 64'hF0,   64'h3C,   F3_AND,    7'd0,   64'h30,   4'b0001};
        vecs[5] = '{1, 64'd3,    64'd5,    F3_ADDSUB, F7_SUB, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1010};
        vecs[6] = '{0, 64'd7,    64'd7,    F3_AND,    7'd0,   64'd7,    4'b0100};

        rst_n = 1'b0;
        req_valid = '1;
        rsp_ready = '0;
        req_op0 = '0; req_op1 = '0; req_func3 = '0; req_func7 = '0;
        @(posedge clk);
        @(negedge clk);
        model_reset();

        // Reset held with all requesters valid
        for (int c = 0; c < 3; c++) begin
            tick(g);
            check("rst_ready", req_ready, '0);
            check("rst_rsp_valid", rsp_valid, '0);
        end
        rst_n = 1'b1;

        // Directed ALU vectors, one at a time
        for (int v = 0; v < 7; v++) begin
            set_req(vecs[v].rq, vecs[v].a, vecs[v].b, vecs[v].f3, vecs[v].f7);
            req_valid = N'(1) << vecs[v].rq;
            rsp_ready = '0;
            tick(g);
            check("vec_grant", g, vecs[v].rq);
            req_valid = '0;
            check("vec_rsp_valid", rsp_valid[vecs[v].rq], 1'b1);
            check("vec_result", rsp_result[vecs[v].rq*W +: W], vecs[v].res);
            check("vec_flags", rsp_flags[vecs[v].rq*4 +: 4], vecs[v].fl);
            tick(g);
            rsp_ready = '1;
            tick(g);
            rsp_ready = '0;
        end

        // Contention after a fresh reset: grants alternate from 0
        rst_n = 1'b0;
        tick(g);
        rst_n = 1'b1;
        set_req(0, 64'd1, 64'd4, F3_SLL, 7'd0);
        set_req(1, 64'd10, 64'd4, F3_ADDSUB, F7_SUB);
        req_valid = '1;
        rsp_ready = '1;
        for (int c = 0; c < 6; c++) tick(seq[c]);
        for (int c = 0; c < 6; c++) check("rr_order", seq[c], c % 2);
        check("cont_res0", rsp_result[0 +: W], 64'd16);
        check("cont_res1", rsp_result[W +: W], 64'd6);
        req_valid = '0;
        tick(g);

        // Backpressure on requester 0
        set_req(0, 64'd5, 64'd3, F3_ADDSUB, 7'd0);
        req_valid = 2'b01;
        rsp_ready = 2'b00;
        tick(g);
        check("bp_first", g, 0);
        set_req(0, 64'hF0, 64'h3C, F3_AND, 7'd0);
        for (int c = 0; c < 3; c++) begin
            tick(g);
            check("bp_stall", g, -1);
            check("bp_hold", rsp_result[0 +: W], 64'd8);
        end
        rsp_ready = 2'b01;
        tick(g);
        check("bp_regrant", g, 0);
        req_valid = '0;
        rsp_ready = '0;
        check("bp_new", rsp_result[0 +: W], 64'h30);
        tick(g);

        // Reset one cycle after a grant
        rsp_ready = '1;
        tick(g);
        rsp_ready = '0;
        req_valid = '1;
        tick(g);
        rst_n = 1'b0;
        tick(g);
        check("mid_rst_valid", rsp_valid, '0);
        rst_n = 1'b1;
        tick(g);
        check("mid_rst_grant", g, 0);

        // Randomised traffic with occasional reset
        hold = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!hold[i]) begin
                    logic [2:0] f3;
                    logic [63:0] a, b;
                    case ($urandom_range(0, 2))
                        0: f3 = F3_ADDSUB;
                        1: f3 = F3_SLL;
                        default: f3 = F3_AND;
                    endcase
                    if ($urandom_range(0, 1) == 0) begin
                        a = 64'($urandom_range(0, 3));
                        b = 64'($urandom_range(0, 3));
                    end else begin
                        a = {$urandom, $urandom};
                        b = {$urandom, $urandom};
                    end
                    set_req(i, a, b, f3, ($urandom_range(0, 1) == 1) ? F7_SUB : 7'd0);
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                end
            end
            rsp_ready = N'($urandom);
            rst_n = ($urandom_range(0, 39) != 0);
            tick(g);
            for (int i = 0; i < N; i++) hold[i] = req_valid[i] && (g != i) && rst_n;
        end
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
